// File: rtl/avalon_cmd_master_if.sv
// ---------------------------------------------------------------------------
// avalon_cmd_master_if
//
// Purpose:
//   Bundles every handshake and bus signal of avalon_cmd_master:
//   - the command port (valid/ready),
//   - the response port (valid/ready),
//   - the single-beat Avalon-MM request/response signals,
//   - the idle status flag.
//   Names keep the i_/o_ prefixes as seen from the master, so a signal
//   reads the same at the module boundary and in waveforms.
//
// Modports:
//   master : the avalon_cmd_master side (drives o_*, samples i_*)
//   slave  : the environment side (drives i_*, samples o_*), i.e. command
//            producer, response consumer and the Avalon slave together
//
// Signal summary:
//   i_Cmd_Valid / o_Cmd_Ready      command handshake
//   i_Cmd_Write                    1 = write, 0 = read
//   i_Cmd_Addr[29:0]               word address
//   i_Cmd_ByteEn[3:0]              byte enables
//   i_Cmd_WriteData[31:0]          write data
//   o_Rsp_Valid / i_Rsp_Ready      response handshake
//   o_Rsp_Write                    echo of the command type
//   o_Rsp_ReadData[31:0]           read data (0 for writes and timeouts)
//   o_Rsp_Timeout                  transfer aborted by timeout
//   o_AV_Addr/ByteEn/WriteData     Avalon request fields
//   o_AV_Read / o_AV_Write         Avalon strobes (never both high)
//   i_AV_ReadData[31:0]            slave read data
//   i_AV_WaitRequest               slave stall
//   o_Idle                         master idle and command FIFO empty
// ---------------------------------------------------------------------------
interface avalon_cmd_master_if;

    logic        i_Cmd_Valid;
    logic        o_Cmd_Ready;
    logic        i_Cmd_Write;
    logic [29:0] i_Cmd_Addr;
    logic [3:0]  i_Cmd_ByteEn;
    logic [31:0] i_Cmd_WriteData;

    logic        o_Rsp_Valid;
    logic        i_Rsp_Ready;
    logic        o_Rsp_Write;
    logic [31:0] o_Rsp_ReadData;
    logic        o_Rsp_Timeout;

    logic [29:0] o_AV_Addr;
    logic [3:0]  o_AV_ByteEn;
    logic [31:0] o_AV_WriteData;
    logic        o_AV_Read;
    logic        o_AV_Write;
    logic [31:0] i_AV_ReadData;
    logic        i_AV_WaitRequest;

    logic        o_Idle;

    modport master (
        input  i_Cmd_Valid,
        output o_Cmd_Ready,
        input  i_Cmd_Write,
        input  i_Cmd_Addr,
        input  i_Cmd_ByteEn,
        input  i_Cmd_WriteData,
        output o_Rsp_Valid,
        input  i_Rsp_Ready,
        output o_Rsp_Write,
        output o_Rsp_ReadData,
        output o_Rsp_Timeout,
        output o_AV_Addr,
        output o_AV_ByteEn,
        output o_AV_WriteData,
        output o_AV_Read,
        output o_AV_Write,
        input  i_AV_ReadData,
        input  i_AV_WaitRequest,
        output o_Idle
    );

    modport slave (
        output i_Cmd_Valid,
        input  o_Cmd_Ready,
        output i_Cmd_Write,
        output i_Cmd_Addr,
        output i_Cmd_ByteEn,
        output i_Cmd_WriteData,
        input  o_Rsp_Valid,
        output i_Rsp_Ready,
        input  o_Rsp_Write,
        input  o_Rsp_ReadData,
        input  o_Rsp_Timeout,
        input  o_AV_Addr,
        input  o_AV_ByteEn,
        input  o_AV_WriteData,
        input  o_AV_Read,
        input  o_AV_Write,
        output i_AV_ReadData,
        output i_AV_WaitRequest,
        input  o_Idle
    );

endinterface

// File: rtl/avalon_cmd_master.sv
// ---------------------------------------------------------------------------
// avalon_cmd_master
//
// Purpose:
//   Command-driven Avalon-MM master. Commands enter a small FIFO through a
//   valid/ready port; each one is issued in order as a single-beat Avalon
//   read or write that honours waitrequest, and each produces exactly one
//   response (read data or write acknowledge, plus a timeout flag) on a
//   valid/ready response port. Only one transfer is outstanding at a time.
//
// Parameters:
//   FIFO_DEPTH     : command FIFO entries, power of two, >= 2
//   TIMEOUT_CYCLES : maximum cycles a strobe is held before abort, >= 1
//
// Ports:
//   i_Clk   : single clock, everything on the rising edge
//   i_Reset : synchronous, active-high reset
//   bus     : avalon_cmd_master_if.master - command, response and Avalon
//             signals (see the interface file for the full list)
//
// Timing summary (W = slave wait cycles, command pushed on the edge that
// ends cycle 0 into an empty FIFO with the FSM idle):
//   strobe high cycles 2 .. 2+W, write response cycle 3+W,
//   read response cycle 4+W. The slave read latency is one cycle.
// ---------------------------------------------------------------------------
module avalon_cmd_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    avalon_cmd_master_if.master bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic        write;
        logic [29:0] addr;
        logic [3:0]  byte_en;
        logic [31:0] write_data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    cmd_t             push_data;
    cmd_t             head;

    state_t           state;
    logic             running;
    logic             cmd_write;
    logic [CNT_W-1:0] wait_cnt;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never opens room for a push while the FIFO is full.
    assign fifo_full  = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // 'running' is low during reset and the first cycle it is asserted, so
    // the ready flag reads 0 while i_Reset is high and rises one cycle
    // after release without decoding i_Reset combinationally.
    assign bus.o_Cmd_Ready = running && !fifo_full;
    assign bus.o_Idle      = running && (state == IDLE) && fifo_empty;

    assign push = bus.i_Cmd_Valid && bus.o_Cmd_Ready;
    assign pop  = (state == IDLE) && !fifo_empty;

    assign push_data = '{
        write:      bus.i_Cmd_Write,
        addr:       bus.i_Cmd_Addr,
        byte_en:    bus.i_Cmd_ByteEn,
        write_data: bus.i_Cmd_WriteData
    };

    assign head = fifo_mem[rd_ptr];

    // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH for
    // free. Storage is not reset; only the pointers and count are.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM with registered outputs
    // ------------------------------------------------------------------

    // The Avalon address/byte-enable/write-data registers double as the
    // command register: they are loaded on the pop and left untouched
    // until the next pop, so they stay stable through ISSUE and hold their
    // last value afterwards.
    //
    // In ISSUE a strobe is always high, so acceptance is simply
    // waitrequest low. Acceptance takes priority over the timeout, so a
    // slave that answers on the very last allowed cycle still completes.
    // wait_cnt equals (cycles the strobe has been high - 1) during ISSUE.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state              <= IDLE;
            running            <= 1'b0;
            cmd_write          <= 1'b0;
            wait_cnt           <= '0;
            bus.o_AV_Addr      <= '0;
            bus.o_AV_ByteEn    <= '0;
            bus.o_AV_WriteData <= '0;
            bus.o_AV_Read      <= 1'b0;
            bus.o_AV_Write     <= 1'b0;
            bus.o_Rsp_Valid    <= 1'b0;
            bus.o_Rsp_Write    <= 1'b0;
            bus.o_Rsp_ReadData <= '0;
            bus.o_Rsp_Timeout  <= 1'b0;
        end else begin
            running <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd_write          <= head.write;
                        bus.o_AV_Addr      <= head.addr;
                        bus.o_AV_ByteEn    <= head.byte_en;
                        bus.o_AV_WriteData <= head.write_data;
                        bus.o_AV_Read      <= !head.write;
                        bus.o_AV_Write     <= head.write;
                        wait_cnt           <= '0;
                        state              <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!bus.i_AV_WaitRequest) begin
                        bus.o_AV_Read  <= 1'b0;
                        bus.o_AV_Write <= 1'b0;
                        wait_cnt       <= '0;
                        if (cmd_write) begin
                            bus.o_Rsp_Valid    <= 1'b1;
                            bus.o_Rsp_Write    <= 1'b1;
                            bus.o_Rsp_ReadData <= '0;
                            bus.o_Rsp_Timeout  <= 1'b0;
                            state              <= RESP;
                        end else begin
                            state <= RDATA;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.o_AV_Read      <= 1'b0;
                        bus.o_AV_Write     <= 1'b0;
                        wait_cnt           <= '0;
                        bus.o_Rsp_Valid    <= 1'b1;
                        bus.o_Rsp_Write    <= cmd_write;
                        bus.o_Rsp_ReadData <= '0;
                        bus.o_Rsp_Timeout  <= 1'b1;
                        state              <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                // The slave presents read data one cycle after acceptance.
                RDATA: begin
                    bus.o_Rsp_Valid    <= 1'b1;
                    bus.o_Rsp_Write    <= 1'b0;
                    bus.o_Rsp_ReadData <= bus.i_AV_ReadData;
                    bus.o_Rsp_Timeout  <= 1'b0;
                    state              <= RESP;
                end

                RESP: begin
                    if (bus.i_Rsp_Ready) begin
                        bus.o_Rsp_Valid <= 1'b0;
                        state           <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_single_strobe: assert property (@(posedge i_Clk) disable iff (i_Reset)
        !(bus.o_AV_Read && bus.o_AV_Write));

endmodule

// File: doc/avalon_cmd_master.md
# avalon_cmd_master

Command-driven Avalon-MM master for the SOC interconnect simulation and bring-up path; it sits directly upstream of Avalon RW slaves (address space selected by upper address bits) and drives their read/write strobes. Commands arrive through a valid/ready port into a small FIFO, each is issued as one single-beat Avalon transfer honouring `i_AV_WaitRequest`, and every command yields exactly one response (read data or write acknowledge, with timeout flag) on a valid/ready response port.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 255: maximum cycles a strobe is held; ≥1.
- `i_Clk` in 1: single clock, all logic on rising edge.
- `i_Reset` in 1: synchronous, active-high reset.
- `i_Cmd_Valid` in 1: command present.
- `o_Cmd_Ready` out 1: FIFO can accept (= not full).
- `i_Cmd_Write` in 1: 1 = write, 0 = read.
- `i_Cmd_Addr` in 30: word address.
- `i_Cmd_ByteEn` in 4: byte enables.
- `i_Cmd_WriteData` in 32: write data.
- `o_Rsp_Valid` out 1: response present.
- `i_Rsp_Ready` in 1: response consumer ready.
- `o_Rsp_Write` out 1: echo of command type.
- `o_Rsp_ReadData` out 32: captured read data; 0 for writes and timeouts.
- `o_Rsp_Timeout` out 1: transfer aborted by timeout.
- `o_AV_Addr` out 30, `o_AV_ByteEn` out 4, `o_AV_WriteData` out 32: Avalon request fields.
- `o_AV_Read` out 1, `o_AV_Write` out 1: Avalon strobes, never both high.
- `i_AV_ReadData` in 32: slave read data.
- `i_AV_WaitRequest` in 1: slave stall.
- `o_Idle` out 1: state IDLE and FIFO empty.

## Operation
- FIFO: push on `i_Cmd_Valid & o_Cmd_Ready`; `o_Cmd_Ready = !full` from registered count; no push when full even if popping that cycle. Pointers wrap modulo `FIFO_DEPTH`.
- FSM states IDLE, ISSUE, RDATA, RESP.
- IDLE: if FIFO non-empty, pop head into command register, go ISSUE. Otherwise stay.
- ISSUE: `o_AV_Read` = !cmd write, `o_AV_Write` = cmd write; addr/byteen/writedata held stable from the command register throughout.
  - Transfer accepted on the edge where a strobe is high and `i_AV_WaitRequest` = 0: write -> RESP; read -> RDATA.
  - Wait counter increments each ISSUE cycle with waitrequest high; when strobe has been high `TIMEOUT_CYCLES` cycles without acceptance -> RESP with timeout=1, read data 0.
- RDATA: strobes low; capture `i_AV_ReadData` (slave read latency fixed at 1 cycle after acceptance), go RESP.
- RESP: `o_Rsp_Valid` = 1, response fields stable until `i_Rsp_Ready` sampled high; then IDLE. Wait counter cleared on leaving ISSUE.
- Outside ISSUE both strobes are 0; `o_AV_Addr`/`ByteEn`/`WriteData` hold last value.
- Only one outstanding transfer; commands are issued strictly in order.

## Timing
- Reset (synchronous): state IDLE, FIFO empty, counter 0, all outputs 0 (`o_Cmd_Ready` 0 while `i_Reset` high, 1 the cycle after release; `o_Idle` 1 after release). Reset mid-transfer: strobes and `o_Rsp_Valid` low from the first edge with `i_Reset` high; queued and in-flight commands discarded, no response issued.
- All outputs registered except `o_Cmd_Ready` and `o_Idle` (decoded from registers).
- Latency, command pushed on edge ending cycle 0, FIFO previously empty, FSM in IDLE: strobe high cycles 2..2+W (W = slave wait cycles); write response valid cycle 3+W; read response valid cycle 4+W.
- Back-to-back: next command's strobe rises two cycles after the response handshake edge (one IDLE cycle).
- Timeout: strobe high exactly `TIMEOUT_CYCLES` cycles, then response valid next cycle.
- Response held indefinitely under `i_Rsp_Ready` = 0; FIFO keeps accepting until full.

## Test plan
- Paired with a test slave (W=0): write 0xDEADBEEF, ByteEn 0xF, addr 0 -> `o_AV_Write` high 1 cycle, response valid cycle 3, Write=1, Timeout=0; read addr 0 -> response valid cycle 4 with ReadData 0xDEADBEEF.
- Slave write/read wait 3: write 0x11223344 ByteEn 0x5 over 0xFFFFFFFF, read back -> strobes high 4 cycles each, addr/data stable, ReadData 0xFF22FF44.
- Push 5 commands with FIFO_DEPTH 4 while FSM stalled by `i_Rsp_Ready` = 0 -> `o_Cmd_Ready` drops at full, commands issued and responded in push order, none lost or duplicated.
- Unselected address (waitrequest held 1), TIMEOUT_CYCLES 8 -> `o_AV_Read` high exactly 8 cycles, response Timeout=1, ReadData 0; following command completes normally.
- Assert `i_Reset` one cycle during ISSUE with 2 commands queued -> strobes low next edge, no response, `o_Idle` 1 after release, FIFO empty.
- Hold `i_Rsp_Ready` low 10 cycles on a read response -> `o_Rsp_Valid` and `o_Rsp_ReadData` stable all 10 cycles, no strobe activity until handshake.
